// File: rtl/bus_pkg.sv
// Shared types and helpers for the two-core snooping bus agents.
// Optional MESI support (Exclusive fills/snoops) is enabled by defining L1_BUS_AGENT_MESI_EN.
package bus_pkg;

  typedef enum logic [1:0] {
    RD   = 2'b00,
    UPGR = 2'b01,
    RDX  = 2'b10,
    NON  = 2'b11
  } bus_op_e;

  typedef enum logic [1:0] {
    PEER = 2'b01,
    L2   = 2'b10,
    NONE = 2'b11
  } hit_src_e;

  typedef enum logic [1:0] {
    I = 2'b00,
    S = 2'b01,
    M = 2'b10,
    E = 2'b11
  } line_state_e;

  localparam int TAG_W_DEFAULT = 24;

`ifdef L1_BUS_AGENT_MESI_EN
  localparam bit MESI_EN = 1'b1;
`else
  localparam bit MESI_EN = 1'b0;
`endif

  // A read nobody else holds may come back Exclusive; any write intent fills Modified.
  function automatic line_state_e fill_for(input logic [1:0] op, input logic [1:0] src);
    if (op == RD) return (MESI_EN && src == NONE) ? E : S;
    return M;
  endfunction

endpackage

// File: rtl/snoop_responder.sv
// Responder side of the L1 bus agent: combinational snoop hit path plus a one-cycle
// registered stage that updates the local line state and flushes Modified data to L2.
module snoop_responder
  import bus_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       snoop_operation_in,
  input  logic [31:0]      snoop_address_in,
  input  logic [1:0]       snoop_state_in,
  input  logic [31:0]      snoop_data_in,
  output logic             cache_hit_out,
  output logic [31:0]      bus_data_out,
  output logic             state_wr_en,
  output logic [31:0]      state_wr_addr,
  output logic [1:0]       state_wr_val,
  output logic             flush_out,
  output logic [31:0]      data_to_L2_out,
  output logic [TAG_W-1:0] tag_to_L2_out
);

  logic [1:0]       eff_state;
  logic             wr_en_d, wr_en_q, flush_d, flush_q;
  logic [31:0]      wr_addr_d, wr_addr_q, l2_data_d, l2_data_q;
  logic [1:0]       wr_val_d, wr_val_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  // Without MESI an Exclusive input behaves exactly like Shared.
  assign eff_state     = (!MESI_EN && snoop_state_in == E) ? S : snoop_state_in;
  assign cache_hit_out = (snoop_operation_in != NON) && (snoop_state_in != I);
  assign bus_data_out  = cache_hit_out ? snoop_data_in : 32'h0;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_val_d  = I;
    wr_addr_d = '0;
    flush_d   = 1'b0;
    l2_data_d = '0;
    tag_d     = '0;
    case (snoop_operation_in)
      RD: begin
        if (eff_state == M) begin
          wr_en_d  = 1'b1;
          wr_val_d = S;
          flush_d  = 1'b1;
        end else if (eff_state == E) begin
          wr_en_d  = 1'b1;
          wr_val_d = S;
        end
      end
      UPGR, RDX: begin
        if (eff_state != I) begin
          wr_en_d  = 1'b1;
          wr_val_d = I;
          flush_d  = (eff_state == M);
        end
      end
      default: ;
    endcase
    if (wr_en_d) wr_addr_d = snoop_address_in;
    if (flush_d) begin
      l2_data_d = snoop_data_in;
      tag_d     = snoop_address_in[31:32-TAG_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_val_q  <= '0;
      wr_addr_q <= '0;
      flush_q   <= 1'b0;
      l2_data_q <= '0;
      tag_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_val_q  <= wr_val_d;
      wr_addr_q <= wr_addr_d;
      flush_q   <= flush_d;
      l2_data_q <= l2_data_d;
      tag_q     <= tag_d;
    end
  end

  assign state_wr_en    = wr_en_q;
  assign state_wr_val   = wr_val_q;
  assign state_wr_addr  = wr_addr_q;
  assign flush_out      = flush_q;
  assign data_to_L2_out = l2_data_q;
  assign tag_to_L2_out  = tag_q;

endmodule

// File: rtl/l1_bus_agent.sv
// Per-core L1 bus agent: initiator FSM (request/grant/fill) plus the snoop responder.
// Build with L1_BUS_AGENT_MESI_EN defined for MESI; the default build is MSI only.
module l1_bus_agent
  import bus_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int TAG_W    = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [1:0]       cpu_op,
  input  logic [31:0]      cpu_addr,
  input  logic [6:0]       cpu_opcode,
  output logic             cpu_done,
  output logic [31:0]      cpu_rdata,
  output logic [1:0]       cpu_src,
  output logic [1:0]       fill_state,
  output logic             stall_core,
  output logic             starve,
  output logic             req_core,
  input  logic             grant_core,
  output logic [1:0]       bus_operation_out,
  output logic [31:0]      bus_address_out,
  output logic [6:0]       opcode_out,
  input  logic [31:0]      bus_data_in,
  input  logic [1:0]       cache_hit_resp,
  input  logic [1:0]       snoop_operation_in,
  input  logic [31:0]      snoop_address_in,
  input  logic [1:0]       snoop_state_in,
  input  logic [31:0]      snoop_data_in,
  output logic             cache_hit_out,
  output logic [31:0]      bus_data_out,
  output logic             state_wr_en,
  output logic [31:0]      state_wr_addr,
  output logic [1:0]       state_wr_val,
  output logic             flush_out,
  output logic [31:0]      data_to_L2_out,
  output logic [TAG_W-1:0] tag_to_L2_out
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} fsm_e;

  fsm_e             state_d, state_q;
  logic [1:0]       bus_op_d, bus_op_q, src_d, src_q, fill_d, fill_q;
  logic [31:0]      addr_d, addr_q, rdata_d, rdata_q;
  logic [6:0]       opc_d, opc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             req_d, req_q, stall_d, stall_q, done_d, done_q, starve_d, starve_q;
  logic             snoop_kills_upgr;

  // A peer's write intent on our line while our upgrade waits means our copy is gone.
  assign snoop_kills_upgr = (bus_op_q == UPGR) &&
                            (snoop_operation_in == UPGR || snoop_operation_in == RDX) &&
                            (snoop_address_in == addr_q);

  always_comb begin
    state_d  = state_q;
    bus_op_d = bus_op_q;
    addr_d   = addr_q;
    opc_d    = opc_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    stall_d  = stall_q;
    done_d   = 1'b0;
    starve_d = starve_q;
    rdata_d  = rdata_q;
    src_d    = src_q;
    fill_d   = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && cpu_op != NON) begin
          bus_op_d = cpu_op;
          addr_d   = cpu_addr;
          opc_d    = cpu_opcode;
          cnt_d    = '0;
          starve_d = 1'b0;
          req_d    = 1'b1;
          stall_d  = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (grant_core) begin
          rdata_d  = bus_data_in;
          src_d    = cache_hit_resp;
          fill_d   = fill_for(bus_op_q, cache_hit_resp);
          cnt_d    = '0;
          starve_d = 1'b0;
          done_d   = 1'b1;
          stall_d  = 1'b0;
          req_d    = 1'b0;
          bus_op_d = NON;
          state_d  = ST_DONE;
        end else begin
          cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          starve_d = (cnt_d == CNT_MAX);
          if (snoop_kills_upgr) bus_op_d = RDX;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bus_op_q <= NON;
      addr_q   <= '0;
      opc_q    <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      stall_q  <= 1'b0;
      done_q   <= 1'b0;
      starve_q <= 1'b0;
      rdata_q  <= '0;
      src_q    <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      bus_op_q <= bus_op_d;
      addr_q   <= addr_d;
      opc_q    <= opc_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      stall_q  <= stall_d;
      done_q   <= done_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
      src_q    <= src_d;
      fill_q   <= fill_d;
    end
  end

  assign cpu_done          = done_q;
  assign cpu_rdata         = rdata_q;
  assign cpu_src           = src_q;
  assign fill_state        = fill_q;
  assign stall_core        = stall_q;
  assign starve            = starve_q;
  assign req_core          = req_q;
  assign bus_operation_out = bus_op_q;
  assign bus_address_out   = addr_q;
  assign opcode_out        = opc_q;

  snoop_responder #(.TAG_W(TAG_W)) u_snoop (
    .clk                (clk),
    .reset              (reset),
    .snoop_operation_in (snoop_operation_in),
    .snoop_address_in   (snoop_address_in),
    .snoop_state_in     (snoop_state_in),
    .snoop_data_in      (snoop_data_in),
    .cache_hit_out      (cache_hit_out),
    .bus_data_out       (bus_data_out),
    .state_wr_en        (state_wr_en),
    .state_wr_addr      (state_wr_addr),
    .state_wr_val       (state_wr_val),
    .flush_out          (flush_out),
    .data_to_L2_out     (data_to_L2_out),
    .tag_to_L2_out      (tag_to_L2_out)
  );

endmodule

// File: tb/tb_l1_bus_agent.sv
// Directed testbench for l1_bus_agent: table-driven snoop vectors plus hand-written
// initiator sequences (fill, starvation, upgrade conflict, reset mid-transaction).
module tb_l1_bus_agent;

`ifdef L1_BUS_AGENT_MESI_EN
  localparam bit MESI = 1'b1;
`else
  localparam bit MESI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [1:0]  cpu_op;
  logic [31:0] cpu_addr;
  logic [6:0]  cpu_opcode;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_src, fill_state;
  logic        stall_core, starve, req_core, grant_core;
  logic [1:0]  bus_operation_out;
  logic [31:0] bus_address_out;
  logic [6:0]  opcode_out;
  logic [31:0] bus_data_in;
  logic [1:0]  cache_hit_resp;
  logic [1:0]  snoop_operation_in;
  logic [31:0] snoop_address_in;
  logic [1:0]  snoop_state_in;
  logic [31:0] snoop_data_in;
  logic        cache_hit_out;
  logic [31:0] bus_data_out;
  logic        state_wr_en;
  logic [31:0] state_wr_addr;
  logic [1:0]  state_wr_val;
  logic        flush_out;
  logic [31:0] data_to_L2_out;
  logic [23:0] tag_to_L2_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1_bus_agent dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_opcode(cpu_opcode),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_src(cpu_src), .fill_state(fill_state),
    .stall_core(stall_core), .starve(starve), .req_core(req_core), .grant_core(grant_core),
    .bus_operation_out(bus_operation_out), .bus_address_out(bus_address_out),
    .opcode_out(opcode_out), .bus_data_in(bus_data_in), .cache_hit_resp(cache_hit_resp),
    .snoop_operation_in(snoop_operation_in), .snoop_address_in(snoop_address_in),
    .snoop_state_in(snoop_state_in), .snoop_data_in(snoop_data_in),
    .cache_hit_out(cache_hit_out), .bus_data_out(bus_data_out),
    .state_wr_en(state_wr_en), .state_wr_addr(state_wr_addr), .state_wr_val(state_wr_val),
    .flush_out(flush_out), .data_to_L2_out(data_to_L2_out), .tag_to_L2_out(tag_to_L2_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [1:0]  st;
    logic [31:0] data;
    logic        hit;
    logic        wr;
    logic [1:0]  val;
    logic        fl;
    logic [23:0] tag;
  } snoop_vec_t;

  snoop_vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // op, addr, state, data, hit, wr, val, flush, tag
    vecs[0] = '{2'b00, 32'h0000_0200, 2'b10, 32'h0000_1234, 1'b1, 1'b1, 2'b01, 1'b1, 24'h000002};
    vecs[1] = '{2'b00, 32'h0000_0204, 2'b01, 32'h0000_AAAA, 1'b1, 1'b0, 2'b00, 1'b0, 24'h0};
    vecs[2] = '{2'b10, 32'h0000_0300, 2'b01, 32'h0000_0055, 1'b1, 1'b1, 2'b00, 1'b0, 24'h0};
    vecs[3] = '{2'b00, 32'h0000_0400, 2'b00, 32'h0000_0099, 1'b0, 1'b0, 2'b00, 1'b0, 24'h0};
    vecs[4] = '{2'b01, 32'hABCD_EF00, 2'b10, 32'hCAFE_F00D, 1'b1, 1'b1, 2'b00, 1'b1, 24'hABCDEF};
    vecs[5] = '{2'b11, 32'h0000_0200, 2'b10, 32'h0000_0077, 1'b0, 1'b0, 2'b00, 1'b0, 24'h0};
    vecs[6] = '{2'b10, 32'h1234_5678, 2'b10, 32'hFEED_FACE, 1'b1, 1'b1, 2'b00, 1'b1, 24'h123456};
    vecs[7] = '{2'b00, 32'h0000_0500, 2'b11, 32'h0000_0011, 1'b1, MESI, MESI ? 2'b01 : 2'b00, 1'b0, 24'h0};
    vecs[8] = '{2'b01, 32'h0000_0600, 2'b11, 32'h0000_0022, 1'b1, 1'b1, 2'b00, 1'b0, 24'h0};
    vecs[9] = '{2'b01, 32'h0000_0700, 2'b00, 32'h0000_0033, 1'b0, 1'b0, 2'b00, 1'b0, 24'h0};

    reset = 1'b1; cpu_req = 1'b0; cpu_op = 2'b11; cpu_addr = '0; cpu_opcode = '0;
    grant_core = 1'b0; bus_data_in = '0; cache_hit_resp = '0;
    snoop_operation_in = 2'b11; snoop_address_in = '0; snoop_state_in = '0; snoop_data_in = '0;
    tick(); tick();

    check("rst_bus_op", 32'(bus_operation_out), 32'h3);
    check("rst_req", 32'(req_core), 32'h0);
    check("rst_stall", 32'(stall_core), 32'h0);
    check("rst_done", 32'(cpu_done), 32'h0);
    check("rst_starve", 32'(starve), 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_fill", 32'(fill_state), 32'h0);
    check("rst_flush", 32'(flush_out), 32'h0);
    reset = 1'b0;
    tick();

    // Snoop table, applied back to back: combinational hit then next-cycle update.
    for (int k = 0; k < 10; k++) begin
      snoop_operation_in = vecs[k].op;
      snoop_address_in   = vecs[k].addr;
      snoop_state_in     = vecs[k].st;
      snoop_data_in      = vecs[k].data;
      #1;
      check($sformatf("v%0d_hit", k), 32'(cache_hit_out), 32'(vecs[k].hit));
      check($sformatf("v%0d_bdata", k), bus_data_out, vecs[k].hit ? vecs[k].data : 32'h0);
      tick();
      check($sformatf("v%0d_wr_en", k), 32'(state_wr_en), 32'(vecs[k].wr));
      check($sformatf("v%0d_wr_val", k), 32'(state_wr_val), 32'(vecs[k].val));
      check($sformatf("v%0d_wr_addr", k), state_wr_addr, vecs[k].wr ? vecs[k].addr : 32'h0);
      check($sformatf("v%0d_flush", k), 32'(flush_out), 32'(vecs[k].fl));
      check($sformatf("v%0d_l2data", k), data_to_L2_out, vecs[k].fl ? vecs[k].data : 32'h0);
      check($sformatf("v%0d_tag", k), 32'(tag_to_L2_out), 32'(vecs[k].tag));
    end
    snoop_operation_in = 2'b11;
    tick();
    check("snoop_pulse_end_wr", 32'(state_wr_en), 32'h0);
    check("snoop_pulse_end_flush", 32'(flush_out), 32'h0);

    // BusRd with grant on the first REQ cycle: cpu_done two edges after cpu_req.
    cpu_req = 1'b1; cpu_op = 2'b00; cpu_addr = 32'h100; cpu_opcode = 7'h33;
    tick();
    cpu_req = 1'b0;
    check("rd_stall", 32'(stall_core), 32'h1);
    check("rd_req", 32'(req_core), 32'h1);
    check("rd_bus_op", 32'(bus_operation_out), 32'h0);
    check("rd_bus_addr", bus_address_out, 32'h100);
    check("rd_opcode", 32'(opcode_out), 32'h33);
    check("rd_done_early", 32'(cpu_done), 32'h0);
    grant_core = 1'b1; bus_data_in = 32'hDEADBEEF; cache_hit_resp = 2'b10;
    tick();
    grant_core = 1'b0;
    check("rd_done", 32'(cpu_done), 32'h1);
    check("rd_rdata", cpu_rdata, 32'hDEADBEEF);
    check("rd_src", 32'(cpu_src), 32'h2);
    check("rd_fill", 32'(fill_state), 32'h1);
    check("rd_stall_drop", 32'(stall_core), 32'h0);
    check("rd_req_drop", 32'(req_core), 32'h0);
    check("rd_bus_non", 32'(bus_operation_out), 32'h3);
    tick();
    check("rd_done_pulse", 32'(cpu_done), 32'h0);

    // Starvation: grant withheld for 20 cycles.
    cpu_req = 1'b1; cpu_op = 2'b10; cpu_addr = 32'h800; cpu_opcode = 7'h05;
    tick();
    cpu_req = 1'b0;
    for (int w = 1; w <= 20; w++) begin
      tick();
      if (w == 14 || w == 15 || w == 20)
        check($sformatf("starve_w%0d", w), 32'(starve), (w >= 15) ? 32'h1 : 32'h0);
      if (w == 20) check("starve_stall", 32'(stall_core), 32'h1);
    end
    grant_core = 1'b1; bus_data_in = 32'h0BADF00D; cache_hit_resp = 2'b01;
    tick();
    grant_core = 1'b0;
    check("starve_done", 32'(cpu_done), 32'h1);
    check("starve_clear", 32'(starve), 32'h0);
    check("starve_src", 32'(cpu_src), 32'h1);
    check("starve_fill", 32'(fill_state), 32'h2);
    tick();

    // Upgrade pending; unrelated snoop leaves it, same-line BusRdX converts it.
    cpu_req = 1'b1; cpu_op = 2'b01; cpu_addr = 32'h300; cpu_opcode = 7'h23;
    tick();
    cpu_req = 1'b0;
    check("upgr_bus_op", 32'(bus_operation_out), 32'h1);
    snoop_operation_in = 2'b10; snoop_address_in = 32'h304; snoop_state_in = 2'b00;
    tick();
    check("upgr_other_addr", 32'(bus_operation_out), 32'h1);
    snoop_address_in = 32'h300; snoop_state_in = 2'b01;
    tick();
    snoop_operation_in = 2'b11;
    check("upgr_to_rdx", 32'(bus_operation_out), 32'h2);
    grant_core = 1'b1; bus_data_in = 32'h1111_2222; cache_hit_resp = 2'b10;
    tick();
    grant_core = 1'b0;
    check("upgr_done", 32'(cpu_done), 32'h1);
    check("upgr_fill", 32'(fill_state), 32'h2);
    tick();

    // cpu_op 11 is ignored.
    cpu_req = 1'b1; cpu_op = 2'b11;
    tick();
    cpu_req = 1'b0;
    check("op11_stall", 32'(stall_core), 32'h0);
    check("op11_req", 32'(req_core), 32'h0);

    // BusRd served from memory: S under MSI, E under MESI.
    cpu_req = 1'b1; cpu_op = 2'b00; cpu_addr = 32'h900; cpu_opcode = 7'h03;
    tick();
    cpu_req = 1'b0;
    grant_core = 1'b1; cache_hit_resp = 2'b11; bus_data_in = 32'h0;
    tick();
    grant_core = 1'b0;
    check("mem_src", 32'(cpu_src), 32'h3);
    check("mem_fill", 32'(fill_state), MESI ? 32'h3 : 32'h1);
    tick();

    // Reset during REQ, with a pending snoop update in the same cycle.
    cpu_req = 1'b1; cpu_op = 2'b00; cpu_addr = 32'hA00; cpu_opcode = 7'h03;
    tick();
    cpu_req = 1'b0;
    check("rstmid_req", 32'(req_core), 32'h1);
    reset = 1'b1;
    snoop_operation_in = 2'b00; snoop_address_in = 32'h200; snoop_state_in = 2'b10;
    snoop_data_in = 32'h5555;
    tick();
    reset = 1'b0;
    snoop_operation_in = 2'b11;
    check("rstmid_bus_op", 32'(bus_operation_out), 32'h3);
    check("rstmid_req_low", 32'(req_core), 32'h0);
    check("rstmid_stall", 32'(stall_core), 32'h0);
    check("rstmid_done", 32'(cpu_done), 32'h0);
    check("rstmid_wr_drop", 32'(state_wr_en), 32'h0);
    check("rstmid_flush_drop", 32'(flush_out), 32'h0);
    grant_core = 1'b1;
    tick();
    grant_core = 1'b0;
    check("rstmid_no_done", 32'(cpu_done), 32'h0);
    check("rstmid_idle_req", 32'(req_core), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
